// File: rtl/config_loader.sv
// rtl/config_loader.sv - serializes host words LSB-first onto the config shift chain, then pulses set
module config_loader #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_start,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic              i_cfg_abort,
    input  logic              i_data_valid,
    input  logic [WORD_W-1:0] i_data_word,
    output logic              o_data_ready,
    output logic              o_shift_enable,
    output logic              o_shift_data,
    output logic              o_set_hard,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  w_remaining_next;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [IDX_W-1:0]  w_bit_idx_next;
    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] w_shreg_next;
    logic              w_error_next;
    logic              w_accept;

    logic r_shift_enable;
    logic r_shift_data;
    logic r_set_hard;
    logic r_busy;
    logic r_done;
    logic r_error;

    // An abort in the same cycle as a valid word must not swallow that word.
    assign o_data_ready = (r_state == S_LOAD) && !i_cfg_abort;
    assign w_accept     = o_data_ready && i_data_valid;

    always_comb begin
        w_next           = r_state;
        w_remaining_next = r_remaining;
        w_bit_idx_next   = r_bit_idx;
        w_shreg_next     = r_shreg;
        w_error_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cfg_start) begin
                    if (i_cfg_len != '0) begin
                        w_next           = S_LOAD;
                        w_remaining_next = i_cfg_len;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (i_cfg_abort) begin
                    w_next           = S_IDLE;
                    w_remaining_next = '0;
                end else if (w_accept) begin
                    w_next         = S_SHIFT;
                    w_shreg_next   = i_data_word;
                    w_bit_idx_next = '0;
                end
            end
            S_SHIFT: begin
                if (i_cfg_abort) begin
                    w_next           = S_IDLE;
                    w_remaining_next = '0;
                end else begin
                    w_shreg_next     = r_shreg >> 1;
                    w_bit_idx_next   = r_bit_idx + IDX_W'(1);
                    w_remaining_next = r_remaining - LEN_W'(1);
                    // Final bit wins over word boundary: leftover upper bits are dropped.
                    if (r_remaining == LEN_W'(1)) begin
                        w_next = S_SET;
                    end else if (r_bit_idx == LAST_IDX) begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_SET:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_remaining    <= '0;
            r_bit_idx      <= '0;
            r_shreg        <= '0;
            r_shift_enable <= 1'b0;
            r_shift_data   <= 1'b0;
            r_set_hard     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_remaining    <= w_remaining_next;
            r_bit_idx      <= w_bit_idx_next;
            r_shreg        <= w_shreg_next;
            r_shift_enable <= (w_next == S_SHIFT);
            r_shift_data   <= (w_next == S_SHIFT) && w_shreg_next[0];
            r_set_hard     <= (w_next == S_SET);
            r_busy         <= (w_next != S_IDLE);
            r_done         <= (w_next == S_DONE);
            r_error        <= w_error_next;
        end
    end

    assign o_shift_enable = r_shift_enable;
    assign o_shift_data   = r_shift_data;
    assign o_set_hard     = r_set_hard;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - table-driven and randomized checks of config_loader against a bit-stream model
module tb_config_loader;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_abort;
    logic              data_valid;
    logic [WORD_W-1:0] data_word;
    logic              data_ready;
    logic              shift_enable;
    logic              shift_data;
    logic              set_hard;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    config_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_start   (cfg_start),
        .i_cfg_len     (cfg_len),
        .i_cfg_abort   (cfg_abort),
        .i_data_valid  (data_valid),
        .i_data_word   (data_word),
        .o_data_ready  (data_ready),
        .o_shift_enable(shift_enable),
        .o_shift_data  (shift_data),
        .o_set_hard    (set_hard),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error)
    );

    typedef struct {
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        int          abort_after;
        int          start_at;
        int          exp_shift;
        int          exp_set;
        int          exp_done;
        int          exp_err;
        int          exp_cycles;
    } vec_t;

    int                n_vec  = 0;
    int                n_miss = 0;
    logic [WORD_W-1:0] words[$];

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Drives one load and observes the chain; the expected bit k is bit k%W of word k/W.
    task automatic run_load(input string tag, input int len, input int stall,
                            input int abort_after, input int start_at,
                            output int n_shift, output int n_set, output int n_done,
                            output int n_err, output int n_cyc, output int order_bad);
        int                widx = 0;
        int                stall_left = 0;
        bit                prev_se = 0, prev_set = 0;
        bit                abort_fired = 0, start_fired = 0, finished = 0;
        logic [WORD_W-1:0] w;
        n_shift = 0; n_set = 0; n_done = 0; n_err = 0; n_cyc = 1; order_bad = 0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_len = LEN_W'(len); cfg_abort = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            if (shift_enable) begin
                if (n_shift >= len || n_shift / WORD_W >= words.size()) begin
                    order_bad++;
                end else begin
                    w = words[n_shift / WORD_W];
                    check($sformatf("%s_bit%0d", tag, n_shift), shift_data, w[n_shift % WORD_W]);
                end
                n_shift++;
            end
            if (set_hard) begin
                n_set++;
                if (!prev_se || shift_enable) order_bad++;
            end
            if (done) begin
                n_done++;
                if (!prev_set) order_bad++;
            end
            if (error) n_err++;
            prev_se  = shift_enable;
            prev_set = set_hard;
            if (!busy) begin
                finished = 1;
            end else begin
                n_cyc++;
                cfg_start = 1'b0;
                cfg_abort = 1'b0;
                if (abort_after >= 0 && !abort_fired && n_shift >= abort_after) begin
                    cfg_abort   = 1'b1;
                    abort_fired = 1;
                end
                if (start_at >= 0 && !start_fired && n_shift >= start_at && shift_enable) begin
                    cfg_start   = 1'b1;
                    cfg_len     = LEN_W'(3);
                    start_fired = 1;
                end
                data_valid = (stall_left == 0) && (widx < words.size());
                data_word  = data_valid ? words[widx] : WORD_W'($urandom);
                #1;
                if (cfg_abort) check({tag, "_ready_in_abort"}, data_ready, 0);
                if (data_ready) begin
                    if (data_valid) begin
                        widx++;
                        stall_left = stall;
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                end
            end
        end
        if (!finished) check({tag, "_timeout_busy"}, busy, 0);
        cfg_start = 1'b0; cfg_abort = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check({tag, "_quiet_after"}, {shift_enable, set_hard, done, error, busy}, 0);
    endtask

    task automatic apply(input string tag, input int len, input int stall, input int abort_after,
                         input int start_at, input int e_shift, input int e_set, input int e_done,
                         input int e_err, input int e_cyc);
        int s, st, d, e, cy, ob;
        run_load(tag, len, stall, abort_after, start_at, s, st, d, e, cy, ob);
        check({tag, "_shifts"}, s, e_shift);
        check({tag, "_sets"}, st, e_set);
        check({tag, "_dones"}, d, e_done);
        check({tag, "_errors"}, e, e_err);
        check({tag, "_cycles"}, cy, e_cyc);
        check({tag, "_order"}, ob, 0);
    endtask

    initial begin
        vec_t tbl[$];
        rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_abort = 1'b0;
        data_valid = 1'b0; data_word = '0;

        //          len  w0            w1            stl abort start shf set don err cyc
        tbl.push_back('{16, 32'h0000A5C3, 32'h00000000, 0, -1, -1, 16, 1, 1, 0, 20});
        tbl.push_back('{40, 32'hFFFFFFFF, 32'h000000AA, 3, -1, -1, 40, 1, 1, 0, 48});
        tbl.push_back('{ 0, 32'h12345678, 32'h00000000, 0, -1, -1,  0, 0, 0, 1,  1});
        tbl.push_back('{20, 32'h0F0F3C3C, 32'h00000000, 0, 10, -1, 10, 0, 0, 0, 12});
        tbl.push_back('{20, 32'h9ABCDEF1, 32'h00000000, 0, -1,  5, 20, 1, 1, 0, 24});
        tbl.push_back('{32, 32'h12345678, 32'hFFFFFFFF, 0, -1, -1, 32, 1, 1, 0, 36});
        tbl.push_back('{33, 32'hDEADBEEF, 32'h00000001, 0, -1, -1, 33, 1, 1, 0, 38});
        tbl.push_back('{ 1, 32'h00000001, 32'h00000000, 0, -1, -1,  1, 1, 1, 0,  5});
        tbl.push_back('{ 8, 32'h000000FF, 32'h00000000, 0,  0, -1,  0, 0, 0, 0,  2});

        repeat (3) @(negedge clk);
        check("reset_outputs", {data_ready, shift_enable, shift_data, set_hard, busy, done, error}, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            words.delete();
            words.push_back(tbl[i].w0);
            words.push_back(tbl[i].w1);
            apply($sformatf("v%0d", i), tbl[i].len, tbl[i].stall, tbl[i].abort_after,
                  tbl[i].start_at, tbl[i].exp_shift, tbl[i].exp_set, tbl[i].exp_done,
                  tbl[i].exp_err, tbl[i].exp_cycles);
        end

        // Reset in the middle of shifting clears everything on the next edge.
        @(negedge clk);
        cfg_start = 1'b1; cfg_len = LEN_W'(20);
        @(negedge clk);
        cfg_start = 1'b0; data_valid = 1'b1; data_word = 32'hFFFFFFFF;
        repeat (6) @(negedge clk);
        check("pre_rst_shifting", {shift_enable, shift_data}, 3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_shift_outputs", {data_ready, shift_enable, shift_data, set_hard, busy, done, error}, 0);
        rst = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_shift_idle", {data_ready, busy}, 0);

        for (int r = 0; r < 25; r++) begin
            int len, stall, k;
            len   = $urandom_range(1, 100);
            stall = $urandom_range(0, 2);
            k     = (len + WORD_W - 1) / WORD_W;
            words.delete();
            for (int j = 0; j < k; j++) words.push_back(WORD_W'($urandom));
            apply($sformatf("rnd%0d", r), len, stall, -1, -1, len, 1, 1, 0,
                  1 + k + len + 2 + stall * (k - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
